// File: rtl/tx_sched.sv
// tx_sched: buffers packed sample words, arbitrates them against command responses, and serialises the winner LSB-byte-first to the UART.
// Ports: clk_i/rst_in clock and async active-low reset; clr_i sync flush;
//   smp_stb_i/smp_i sample strobe and word; rsp_req_i/rsp_i/rsp_ack_o response handshake;
//   tx_vld_o/tx_rdy_i/tx_o byte stream; level_o FIFO fill; ovf_o sticky drop; busy_o activity.
module tx_sched #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_in,
  input  logic                      clr_i,
  input  logic                      smp_stb_i,
  input  logic [WORD_BYTES*8-1:0]   smp_i,
  input  logic                      rsp_req_i,
  input  logic [WORD_BYTES*8-1:0]   rsp_i,
  output logic                      rsp_ack_o,
  output logic                      tx_vld_o,
  input  logic                      tx_rdy_i,
  output logic [7:0]                tx_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      ovf_o,
  output logic                      busy_o
);
  localparam int W  = WORD_BYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    mem [DEPTH];
  logic            idle, smp_c, gnt_rsp, gnt_smp, push, hs;
  // last_q: 0 = sample granted last, 1 = response granted last
  always_comb begin
    idle    = state_q == IDLE;
    smp_c   = level_q != '0;
    gnt_rsp = idle && !clr_i && rsp_req_i && (!smp_c || !last_q);
    gnt_smp = idle && !clr_i && smp_c && (!rsp_req_i || last_q);
    // a full FIFO still accepts a word when the head leaves in the same cycle
    push    = smp_stb_i && !clr_i && (level_q != LW'(DEPTH) || gnt_smp);
    hs      = !idle && tx_rdy_i;
    state_d = state_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = gnt_smp ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(gnt_smp);
    ovf_d   = ovf_q || (smp_stb_i && !clr_i && !push);
    if (clr_i) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else if (gnt_rsp || gnt_smp) begin
      state_d = SEND;
      shreg_d = gnt_rsp ? rsp_i : mem[rd_q];
      cnt_d   = '0;
      last_d  = gnt_rsp;
    end else if (hs) begin
      shreg_d = shreg_q >> 8;
      cnt_d   = cnt_q + CW'(1);
      state_d = cnt_q == CW'(WORD_BYTES - 1) ? IDLE : SEND;
    end
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= smp_i;
  end
  // the ack is combinational, so it is masked while reset holds the FSM in IDLE
  assign rsp_ack_o = gnt_rsp && rst_in;
  assign tx_vld_o  = !idle;
  assign tx_o      = shreg_q[7:0];
  assign level_o   = level_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = !idle || smp_c;
endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: scoreboard bench for tx_sched; expected bytes are queued as stimulus is driven and popped on each UART handshake.
`timescale 1ns/1ps
module tb_tx_sched;
  logic        clk_i = 0, rst_in = 1, clr_i = 0, smp_stb_i = 0, rsp_req_i = 0, tx_rdy_i = 0;
  logic [31:0] smp_i = 0, rsp_i = 0;
  logic        rsp_ack_o, tx_vld_o, ovf_o, busy_o;
  logic [7:0]  tx_o;
  logic [2:0]  level_o;
  int          n_chk = 0, n_pass = 0, acks = 0;
  logic [7:0]  q[$];
  logic        stall = 0;
  logic [7:0]  hold = 0;
  logic [31:0] s_w [6];
  logic [31:0] r_w [4];
  always #5 clk_i = ~clk_i;
  tx_sched #(.WORD_BYTES(4), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .clr_i(clr_i),
    .smp_stb_i(smp_stb_i), .smp_i(smp_i),
    .rsp_req_i(rsp_req_i), .rsp_i(rsp_i), .rsp_ack_o(rsp_ack_o),
    .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i), .tx_o(tx_o),
    .level_o(level_o), .ovf_o(ovf_o), .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask
  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) q.push_back(w[i*8 +: 8]);
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic strobe(input logic [31:0] w);
    tick();
    smp_stb_i = 1;
    smp_i = w;
  endtask
  task automatic drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk_i);
      k++;
    end
    chk({tag, "_drain"}, q.size(), 0);
    @(negedge clk_i);
    chk({tag, "_busy"}, busy_o, 0);
  endtask
  always @(negedge clk_i) begin
    if (!rst_in) stall = 0;
    else begin
      if (stall) begin
        chk("hold_vld", tx_vld_o, 1);
        chk("hold_byte", tx_o, hold);
      end
      if (rsp_ack_o) begin
        acks++;
        chk("ack_idle", tx_vld_o, 0);
      end
      if (tx_vld_o && tx_rdy_i) begin
        if (q.size() == 0) chk("extra_byte", {24'd0, tx_o}, 32'h100);
        else chk("byte", tx_o, q.pop_front());
      end
      stall = tx_vld_o && !tx_rdy_i && !clr_i;
      hold = tx_o;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog n_pass %0d n_chk %0d", n_pass, n_chk);
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 6; i++) s_w[i] = {8'h50 + 8'(i), 8'h60 + 8'(i), 8'h70 + 8'(i), 8'h80 + 8'(i)};
    for (int i = 0; i < 4; i++) r_w[i] = {8'hC0 + 8'(i), 8'hD0 + 8'(i), 8'hE0 + 8'(i), 8'hF0 + 8'(i)};
    #2 rst_in = 0;
    rsp_req_i = 1;
    #10;
    chk("rst_ack", rsp_ack_o, 0);
    chk("rst_vld", tx_vld_o, 0);
    chk("rst_tx", tx_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_busy", busy_o, 0);
    rsp_req_i = 0;
    tick();
    rst_in = 1;
    tx_rdy_i = 1;
    // single sample: grant one cycle after the strobe, bytes on the following four cycles
    strobe(32'h44332211);
    push_word(32'h44332211);
    tick();
    smp_stb_i = 0;
    @(negedge clk_i);
    chk("single_level", level_o, 1);
    chk("single_vld0", tx_vld_o, 0);
    @(negedge clk_i);
    chk("single_vld1", tx_vld_o, 1);
    chk("single_b0", tx_o, 8'h11);
    drain("single");
    // backpressure with ready pattern 1,0,0 repeating
    tx_rdy_i = 0;
    strobe(32'hAABBCCDD);
    push_word(32'hAABBCCDD);
    tick();
    smp_stb_i = 0;
    for (int k = 0; k < 60 && q.size() != 0; k++) begin
      tx_rdy_i = (k % 3 == 0);
      tick();
    end
    tx_rdy_i = 1;
    drain("bp");
    // overflow: six back-to-back strobes with the UART stalled
    tx_rdy_i = 0;
    for (int i = 0; i < 6; i++) strobe(32'hA0A0A000 + 32'(i));
    tick();
    smp_stb_i = 0;
    @(negedge clk_i);
    chk("ovf_level", level_o, 4);
    chk("ovf_flag", ovf_o, 1);
    chk("ovf_vld", tx_vld_o, 1);
    tick();
    clr_i = 1;
    smp_stb_i = 1;
    smp_i = 32'hDEADBEEF;
    tick();
    clr_i = 0;
    smp_stb_i = 0;
    @(negedge clk_i);
    chk("clr_level", level_o, 0);
    chk("clr_ovf", ovf_o, 0);
    chk("clr_vld", tx_vld_o, 0);
    chk("clr_busy", busy_o, 0);
    // arbitration: response first, then two buffered samples
    tx_rdy_i = 1;
    acks = 0;
    push_word(32'h534C4131);
    push_word(32'h0A0B0C0D);
    push_word(32'h01020304);
    tick();
    rsp_req_i = 1;
    rsp_i = 32'h534C4131;
    smp_stb_i = 1;
    smp_i = 32'h0A0B0C0D;
    @(negedge clk_i);
    chk("arb_ack", rsp_ack_o, 1);
    tick();
    rsp_req_i = 0;
    smp_i = 32'h01020304;
    tick();
    smp_stb_i = 0;
    @(negedge clk_i);
    chk("arb_level", level_o, 2);
    drain("arb");
    chk("arb_acks", acks, 1);
    // alternation: responses re-raised after each grant, samples kept queued
    tx_rdy_i = 0;
    acks = 0;
    push_word(s_w[0]);
    for (int i = 0; i < 4; i++) begin
      push_word(r_w[i]);
      if (i < 3) push_word(s_w[i + 1]);
    end
    push_word(s_w[4]);
    push_word(s_w[5]);
    for (int i = 0; i < 4; i++) strobe(s_w[i]);
    tick();
    smp_stb_i = 0;
    tx_rdy_i = 1;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      rsp_req_i = 1;
      rsp_i = r_w[i];
      @(negedge clk_i);
      while (!rsp_ack_o && k < 100) begin
        @(negedge clk_i);
        k++;
      end
      chk("alt_ack", rsp_ack_o, 1);
      tick();
      rsp_req_i = 0;
      if (i == 2) begin
        smp_stb_i = 1;
        smp_i = s_w[4];
        tick();
        smp_i = s_w[5];
        tick();
        smp_stb_i = 0;
      end
      tick();
    end
    drain("alt");
    chk("alt_acks", acks, 4);
    chk("alt_ovf", ovf_o, 0);
    // async reset during byte 2 of a word, with another word buffered
    push_word(32'h11223344);
    strobe(32'h11223344);
    strobe(32'h55667788);
    tick();
    smp_stb_i = 0;
    tick();
    tick();
    #1 rst_in = 0;
    #1;
    chk("arst_vld", tx_vld_o, 0);
    chk("arst_level", level_o, 0);
    chk("arst_busy", busy_o, 0);
    q.delete();
    tick();
    rst_in = 1;
    push_word(32'h99AABBCC);
    strobe(32'h99AABBCC);
    tick();
    smp_stb_i = 0;
    drain("post_rst");
    repeat (8) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
